// File: rtl/ft245_pkg.sv
// Shared types and parameter defaults for the FT245 synchronous FIFO bus scheduler.
// Holds the scheduler state encoding, the transfer direction type and the
// default burst / idle-timeout limits used by ft245_bus_sched.
package ft245_pkg;

    // Scheduler states; IDLE is all-zero so a cleared register is a safe state.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RX_OE    = 3'd1,
        ST_RX_READ  = 3'd2,
        ST_RX_END   = 3'd3,
        ST_TX_WRITE = 3'd4
    } state_e;

    // Direction last served, used to break RX/TX ties fairly.
    typedef enum logic {
        DIR_RX = 1'b0,
        DIR_TX = 1'b1
    } dir_e;

    localparam int BURST_MAX_DEF    = 64;
    localparam int IDLE_TIMEOUT_DEF = 255;

endpackage

// File: rtl/ft245_siwua_timer.sv
// Send-immediate timer: after the last FPGA->host byte, counts idle cycles and
// pulses siwua_n low for one cycle once IDLE_TIMEOUT idle cycles have elapsed.
// Ports: io_clk/rst (async, active-high), tx_done (a TX byte completed this
// cycle), siwua_n (registered, active-low one-cycle strobe in the cycle after
// the IDLE_TIMEOUT-th idle cycle).
module ft245_siwua_timer
    import ft245_pkg::*;
#(
    parameter int IDLE_TIMEOUT = IDLE_TIMEOUT_DEF
) (
    input  logic io_clk,
    input  logic rst,
    input  logic tx_done,
    output logic siwua_n
);

    localparam logic [7:0] IDLE_LIM = 8'(IDLE_TIMEOUT);

    logic [7:0] idle_cnt_q, idle_cnt_d;
    logic       armed_q, armed_d;
    logic       pulse_q, pulse_d;

    // The counter only runs once a byte has gone out, and disarms after
    // firing so an idle link produces a single strobe rather than a train.
    always_comb begin
        idle_cnt_d = idle_cnt_q;
        armed_d    = armed_q;
        pulse_d    = 1'b0;
        if (tx_done) begin
            idle_cnt_d = 8'd0;
            armed_d    = 1'b1;
        end else if (armed_q) begin
            if (idle_cnt_q + 8'd1 == IDLE_LIM) begin
                pulse_d    = 1'b1;
                idle_cnt_d = 8'd0;
                armed_d    = 1'b0;
            end else begin
                idle_cnt_d = idle_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge io_clk or posedge rst) begin
        if (rst) begin
            idle_cnt_q <= 8'd0;
            armed_q    <= 1'b0;
            pulse_q    <= 1'b0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
            armed_q    <= armed_d;
            pulse_q    <= pulse_d;
        end
    end

    assign siwua_n = ~pulse_q;

endmodule

// File: rtl/ft245_bus_sched.sv
// FT245 synchronous-FIFO bus scheduler: arbitrates the shared 8-bit bus between
// host->FPGA reads (rx_*) and FPGA->host writes (tx_*) in bursts of up to
// BURST_MAX bytes, alternating direction on ties, with a turnaround cycle
// whenever the bus changes driver.
// Ports: io_clk, rst (async active-high); FT245 side io_rxf_n, io_txe_n,
// io_d_in, io_d_out, io_d_oe, io_oe_n, io_rd_n, io_wr_n, io_siwua_n;
// stream side tx_data/tx_valid/tx_ready and rx_data/rx_valid/rx_ready.
// Build option: define FT245_SIWUA_EN to enable the send-immediate idle
// timer; otherwise io_siwua_n is held high.
module ft245_bus_sched
    import ft245_pkg::*;
#(
    parameter int BURST_MAX    = BURST_MAX_DEF,
    parameter int IDLE_TIMEOUT = IDLE_TIMEOUT_DEF
) (
    input  logic       io_clk,
    input  logic       rst,
    input  logic       io_rxf_n,
    input  logic       io_txe_n,
    input  logic [7:0] io_d_in,
    output logic [7:0] io_d_out,
    output logic       io_d_oe,
    output logic       io_oe_n,
    output logic       io_rd_n,
    output logic       io_wr_n,
    output logic       io_siwua_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready
);

    if (BURST_MAX < 1 || BURST_MAX > 255) begin : g_bad_burst_max
        $error("ft245_bus_sched: BURST_MAX must be within 1..255");
    end
    if (IDLE_TIMEOUT < 1 || IDLE_TIMEOUT > 255) begin : g_bad_idle_timeout
        $error("ft245_bus_sched: IDLE_TIMEOUT must be within 1..255");
    end

    localparam logic [7:0] BURST_LIM = 8'(BURST_MAX);

    state_e     state_q, state_d;
    dir_e       last_dir_q, last_dir_d;
    logic [7:0] burst_cnt_q, burst_cnt_d;

    logic rx_pend;
    logic tx_pend;
    logic rx_xfer;
    logic tx_xfer;
    logic burst_last;

    assign rx_pend = ~io_rxf_n;
    assign tx_pend = ~io_txe_n & tx_valid;

    // A byte moves in any cycle of the active data state where both the FT245
    // and the stream side agree; strobes and handshakes follow directly.
    assign rx_xfer = (state_q == ST_RX_READ)  & rx_ready & ~io_rxf_n;
    assign tx_xfer = (state_q == ST_TX_WRITE) & tx_valid & ~io_txe_n;

    // True when the transfer in this cycle (if any) would be the last one the
    // burst may carry; the counter stays below BURST_LIM so it never wraps.
    assign burst_last = (burst_cnt_q + 8'd1) == BURST_LIM;

    // Bus-side outputs are decoded from the state register so io_oe_n and
    // io_d_oe can never be active together and both drop on async reset.
    assign io_oe_n  = ~((state_q == ST_RX_OE) | (state_q == ST_RX_READ));
    assign io_d_oe  = (state_q == ST_TX_WRITE);
    assign io_d_out = io_d_oe ? tx_data : 8'h00;
    assign io_rd_n  = ~rx_xfer;
    assign io_wr_n  = ~tx_xfer;
    assign rx_valid = rx_xfer;
    assign rx_data  = io_d_in;
    assign tx_ready = tx_xfer;

    always_comb begin
        state_d     = state_q;
        last_dir_d  = last_dir_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            ST_IDLE: begin
                burst_cnt_d = 8'd0;
                // On a tie, serve whichever direction did not go last.
                if (rx_pend && (!tx_pend || last_dir_q == DIR_TX)) begin
                    state_d = ST_RX_OE;
                end else if (tx_pend) begin
                    state_d = ST_TX_WRITE;
                end
            end
            ST_RX_OE: begin
                state_d = ST_RX_READ;
            end
            ST_RX_READ: begin
                if (rx_xfer) begin
                    burst_cnt_d = burst_cnt_q + 8'd1;
                end
                if (!rx_xfer || burst_last) begin
                    state_d = ST_RX_END;
                end
            end
            ST_RX_END: begin
                state_d    = ST_IDLE;
                last_dir_d = DIR_RX;
            end
            ST_TX_WRITE: begin
                if (tx_xfer) begin
                    burst_cnt_d = burst_cnt_q + 8'd1;
                end
                // Returning through IDLE releases io_d_oe for a cycle before
                // the FT245 may be asked to drive the bus.
                if (!tx_xfer || burst_last) begin
                    state_d    = ST_IDLE;
                    last_dir_d = DIR_TX;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge io_clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            last_dir_q  <= DIR_TX;
            burst_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            last_dir_q  <= last_dir_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

`ifdef FT245_SIWUA_EN
    ft245_siwua_timer #(
        .IDLE_TIMEOUT (IDLE_TIMEOUT)
    ) u_siwua_timer (
        .io_clk  (io_clk),
        .rst     (rst),
        .tx_done (tx_xfer),
        .siwua_n (io_siwua_n)
    );
`else
    assign io_siwua_n = 1'b1;
`endif

endmodule

// File: tb/tb_ft245_bus_sched.sv
// Directed bench for ft245_bus_sched built with BURST_MAX=4, IDLE_TIMEOUT=10.
// Each cycle: inputs change 1 time unit after the rising edge, outputs are
// compared 1 unit later, well away from the next edge.
module tb_ft245_bus_sched;

    logic       io_clk = 1'b0;
    logic       rst;
    logic       io_rxf_n;
    logic       io_txe_n;
    logic [7:0] io_d_in;
    logic [7:0] io_d_out;
    logic       io_d_oe;
    logic       io_oe_n;
    logic       io_rd_n;
    logic       io_wr_n;
    logic       io_siwua_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    int tests = 0;
    int fails = 0;

    always #5 io_clk = ~io_clk;

    ft245_bus_sched #(
        .BURST_MAX    (4),
        .IDLE_TIMEOUT (10)
    ) dut (
        .io_clk     (io_clk),
        .rst        (rst),
        .io_rxf_n   (io_rxf_n),
        .io_txe_n   (io_txe_n),
        .io_d_in    (io_d_in),
        .io_d_out   (io_d_out),
        .io_d_oe    (io_d_oe),
        .io_oe_n    (io_oe_n),
        .io_rd_n    (io_rd_n),
        .io_wr_n    (io_wr_n),
        .io_siwua_n (io_siwua_n),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready)
    );

    // Bus pin snapshot {io_oe_n, io_rd_n, io_wr_n, io_d_oe}
    localparam logic [3:0] P_IDLE    = 4'b1110; // IDLE or RX_END
    localparam logic [3:0] P_RX_OE   = 4'b0110; // RX_OE, or RX_READ with no byte
    localparam logic [3:0] P_RX_RD   = 4'b0010; // RX_READ moving a byte
    localparam logic [3:0] P_TX_WR   = 4'b1101; // TX_WRITE moving a byte
    localparam logic [3:0] P_TX_HOLD = 4'b1111; // TX_WRITE with no byte

    logic [3:0] seq_c [19];
    logic [3:0] pin_d [12];
    logic       rdy_d [12];
    logic [7:0] dat_d [12];
    logic [3:0] seq_e [9];

    function automatic logic [31:0] pins();
        return {28'd0, io_oe_n, io_rd_n, io_wr_n, io_d_oe};
    endfunction

    task automatic tick();
        @(posedge io_clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int idx;
        int lows;
        int first_low;

        rst      = 1'b1;
        io_rxf_n = 1'b1;
        io_txe_n = 1'b1;
        io_d_in  = 8'h00;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        rx_ready = 1'b0;

        // ---- reset state
        tick();
        settle();
        chk("rst pins", pins(), 32'(P_IDLE));
        chk("rst siwua_n", 32'(io_siwua_n), 32'd1);
        chk("rst d_out", 32'(io_d_out), 32'h00);
        chk("rst rx_valid", 32'(rx_valid), 32'd0);
        chk("rst tx_ready", 32'(tx_ready), 32'd0);
        tick();
        rst = 1'b0;

        // ---- A: three host bytes, consumer always ready
        tick();
        io_rxf_n = 1'b0; rx_ready = 1'b1; io_d_in = 8'hA1;
        settle();
        chk("A idle", pins(), 32'(P_IDLE));
        tick(); settle();
        chk("A rx_oe", pins(), 32'(P_RX_OE));
        chk("A rx_oe valid", 32'(rx_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            io_d_in = 8'(8'hA1 + i);
            settle();
            chk("A read pins", pins(), 32'(P_RX_RD));
            chk("A rx_valid", 32'(rx_valid), 32'd1);
            chk("A rx_data", 32'(rx_data), 32'(8'hA1 + i));
        end
        tick();
        io_rxf_n = 1'b1;
        settle();
        chk("A empty read", pins(), 32'(P_RX_OE));
        chk("A empty valid", 32'(rx_valid), 32'd0);
        tick(); settle();
        chk("A rx_end", pins(), 32'(P_IDLE));
        tick(); settle();
        chk("A back idle", pins(), 32'(P_IDLE));

        // ---- B: five FPGA bytes, burst of 4 then re-arbitration
        tick();
        io_txe_n = 1'b0; tx_valid = 1'b1; tx_data = 8'h10;
        settle();
        chk("B idle", pins(), 32'(P_IDLE));
        chk("B idle tx_ready", 32'(tx_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            tx_data = 8'(8'h10 + i);
            settle();
            chk("B write pins", pins(), 32'(P_TX_WR));
            chk("B d_out", 32'(io_d_out), 32'(8'h10 + i));
            chk("B tx_ready", 32'(tx_ready), 32'd1);
        end
        tick();
        tx_data = 8'h14;
        settle();
        chk("B burst turnaround", pins(), 32'(P_IDLE));
        tick(); settle();
        chk("B fifth write", pins(), 32'(P_TX_WR));
        chk("B fifth d_out", 32'(io_d_out), 32'h14);
        tick();
        tx_valid = 1'b0;
        settle();
        chk("B no data", pins(), 32'(P_TX_HOLD));
        chk("B no data ready", 32'(tx_ready), 32'd0);
        tick(); settle();
        chk("B d_oe released", pins(), 32'(P_IDLE));

        // ---- C: both directions pending, grants alternate RX, TX, RX
        seq_c = '{P_IDLE, P_RX_OE, P_RX_RD, P_RX_RD, P_RX_RD, P_RX_RD, P_IDLE,
                  P_IDLE, P_TX_WR, P_TX_WR, P_TX_WR, P_TX_WR, P_IDLE,
                  P_RX_OE, P_RX_RD, P_RX_RD, P_RX_RD, P_RX_RD, P_IDLE};
        tick();
        io_rxf_n = 1'b0; rx_ready = 1'b1; io_d_in = 8'h55;
        io_txe_n = 1'b0; tx_valid = 1'b1; tx_data = 8'h66;
        settle();
        chk("C cycle 0", pins(), 32'(seq_c[0]));
        for (int k = 1; k < 19; k++) begin
            tick(); settle();
            chk($sformatf("C cycle %0d", k), pins(), 32'(seq_c[k]));
        end
        tick();
        io_rxf_n = 1'b1; io_txe_n = 1'b1; tx_valid = 1'b0; rx_ready = 1'b0;
        settle();
        chk("C quiet", pins(), 32'(P_IDLE));

        // ---- D: consumer stalls mid-burst, FT245 FIFO holds C0,C1,C2
        pin_d = '{P_IDLE, P_RX_OE, P_RX_RD, P_RX_OE, P_IDLE, P_IDLE,
                  P_RX_OE, P_RX_RD, P_RX_RD, P_RX_OE, P_IDLE, P_IDLE};
        rdy_d = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1,
                  1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        dat_d = '{8'h00, 8'h00, 8'hC0, 8'h00, 8'h00, 8'h00,
                  8'h00, 8'hC1, 8'hC2, 8'h00, 8'h00, 8'h00};
        idx = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            rx_ready = rdy_d[k];
            io_rxf_n = (idx >= 3);
            io_d_in  = 8'(8'hC0 + idx);
            settle();
            chk($sformatf("D cycle %0d pins", k), pins(), 32'(pin_d[k]));
            if (pin_d[k] == P_RX_RD) begin
                chk($sformatf("D cycle %0d data", k), 32'(rx_data), 32'(dat_d[k]));
            end
            // FT245 model pops its FIFO on every read strobe
            if (!io_rd_n) idx++;
        end
        chk("D bytes popped", 32'(idx), 32'd3);

        // ---- E: reset during second TX byte, both directions pending
        tick();
        io_rxf_n = 1'b0; rx_ready = 1'b0;
        io_txe_n = 1'b0; tx_valid = 1'b1; tx_data = 8'h3C;
        settle();
        chk("E idle", pins(), 32'(P_IDLE));
        tick(); settle();
        chk("E byte 1", pins(), 32'(P_TX_WR));
        tick(); settle();
        chk("E byte 2", pins(), 32'(P_TX_WR));
        rst = 1'b1;
        #1;
        chk("E async pins", pins(), 32'(P_IDLE));
        chk("E async d_out", 32'(io_d_out), 32'h00);
        chk("E async tx_ready", 32'(tx_ready), 32'd0);
        tick(); settle();
        chk("E held in reset", pins(), 32'(P_IDLE));
        rst = 1'b0;
        settle();
        chk("E idle on release", pins(), 32'(P_IDLE));
        // last_dir resets to TX, so RX wins the tie right after reset
        seq_e = '{P_RX_OE, P_RX_OE, P_IDLE, P_IDLE,
                  P_TX_WR, P_TX_WR, P_TX_WR, P_TX_WR, P_IDLE};
        for (int k = 0; k < 9; k++) begin
            tick(); settle();
            chk($sformatf("E cycle %0d", k), pins(), 32'(seq_e[k]));
        end
        io_rxf_n = 1'b1; io_txe_n = 1'b1; tx_valid = 1'b0;
        tick(); settle();
        chk("E quiet", pins(), 32'(P_IDLE));

        // ---- F: one TX byte, then an idle link
        tick();
        io_txe_n = 1'b0; tx_valid = 1'b1; tx_data = 8'h77;
        settle();
        tick(); settle();
        chk("F byte", pins(), 32'(P_TX_WR));
        lows = 0;
        first_low = 0;
        for (int n = 1; n <= 20; n++) begin
            tick();
            tx_valid = 1'b0;
            settle();
            if (!io_siwua_n) begin
                lows++;
                if (first_low == 0) first_low = n;
            end
        end
`ifdef FT245_SIWUA_EN
        chk("F siwua low cycles", 32'(lows), 32'd1);
        chk("F siwua position", 32'(first_low), 32'd11);
`else
        chk("F siwua held high", 32'(lows), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ft245_bus_sched.md
FT245_BUS_SCHED -- requirements
Module: ft245_bus_sched

Interface
REQ-001 Parameter BURST_MAX, default 64: maximum transfers per direction grant before re-arbitration; range 1..255.
REQ-002 Parameter IDLE_TIMEOUT, default 255: TX-idle cycles before a send-immediate pulse (used only under FT245_SIWUA_EN); range 1..255.
REQ-003 io_clk  in  1  FT245 60 MHz bus clock; sole clock; all logic on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 io_rxf_n  in  1  low: FT245 holds host->FPGA data.
REQ-006 io_txe_n  in  1  low: FT245 can accept FPGA->host data.
REQ-007 io_d_in  in  8  FT245 data bus, input side.
REQ-008 io_d_out  out  8  FT245 data bus, output side.
REQ-009 io_d_oe  out  1  high: FPGA drives the data bus.
REQ-010 io_oe_n, io_rd_n, io_wr_n, io_siwua_n  out  1 each  FT245 strobes, active-low.
REQ-011 tx_data/tx_valid/tx_ready  in 8/in 1/out 1  FPGA->host stream, valid/ready.
REQ-012 rx_data/rx_valid/rx_ready  out 8/out 1/in 1  host->FPGA stream, valid/ready.

Function
REQ-013 States: IDLE, RX_OE, RX_READ, RX_END, TX_WRITE; encoded state register, reset to IDLE.
REQ-014 IDLE: all strobes high, io_d_oe=0; rx_pend = !io_rxf_n; tx_pend = !io_txe_n & tx_valid.
REQ-015 IDLE arbitration: only one pending -> grant it; both pending -> grant the direction not served last (last_dir reg, reset = TX, so RX wins first tie).
REQ-016 RX grant: IDLE->RX_OE; RX_OE drives io_oe_n=0, io_rd_n=1 for exactly one cycle, then RX_READ.
REQ-017 RX_READ: io_oe_n=0; io_rd_n = !(rx_ready & !io_rxf_n) combinationally; rx_data = io_d_in; rx_valid = !io_rd_n; one byte per cycle with rx_valid & rx_ready.
REQ-018 RX_READ->RX_END when io_rxf_n high, rx_ready low, or burst count reaches BURST_MAX; the transfer in the exit cycle still completes if its conditions held.
REQ-019 RX_END: io_oe_n=1, io_rd_n=1 for one cycle (bus turnaround), then IDLE; last_dir<=RX.
REQ-020 TX grant: IDLE->TX_WRITE; io_d_oe=1, io_d_out=tx_data; io_wr_n = !(tx_valid & !io_txe_n); tx_ready = !io_wr_n.
REQ-021 TX_WRITE->IDLE when io_txe_n high, tx_valid low, or burst count reaches BURST_MAX; last_dir<=TX; io_d_oe drops in IDLE, giving one turnaround cycle before any RX_OE.
REQ-022 Burst counter: 8-bit, cleared on every grant, +1 per completed transfer; never wraps (BURST_MAX<=255).
REQ-023 Outside their states: tx_ready=0, rx_valid=0, io_rd_n=1, io_wr_n=1; io_d_oe and io_oe_n never both active.

Reset
REQ-024 rst asserted asynchronously forces IDLE, io_oe_n/io_rd_n/io_wr_n/io_siwua_n=1, io_d_oe=0, io_d_out=0, counters 0, last_dir=TX; mid-burst reset abandons the transfer with no further strobe.

Configuration
REQ-025 FT245_SIWUA_EN defined: TX-idle counter counts cycles in which no TX byte completes after at least one did; at IDLE_TIMEOUT it pulses io_siwua_n low one cycle and clears; any TX byte restarts it.
REQ-026 FT245_SIWUA_EN undefined: io_siwua_n tied 1, no idle counter logic.

Structure
REQ-027 Shared package ft245_pkg: state enum, direction enum (RX/TX), BURST_MAX/IDLE_TIMEOUT defaults.
REQ-028 One sub-module ft245_siwua_timer holds the REQ-025 counter; instantiated only under FT245_SIWUA_EN.

Verification
REQ-029 rxf_n low 3 cycles, rx_ready=1 -> RX_OE then bytes 0xA1,0xA2,0xA3 delivered in order, RX_END one cycle, back to IDLE.
REQ-030 tx_valid with 5 bytes, txe_n low -> 5 io_wr_n low cycles, io_d_out matches, io_d_oe=0 in following cycle.
REQ-031 Both pending continuously, BURST_MAX=4 -> grants alternate RX,TX,RX, 4 transfers each, turnaround cycle between.
REQ-032 rx_ready low for 2 cycles mid-burst -> io_rd_n high those cycles, exit to RX_END, no byte lost or duplicated.
REQ-033 rst pulsed during TX_WRITE byte 2 -> strobes high, io_d_oe=0 immediately, IDLE on release.
REQ-034 FT245_SIWUA_EN, IDLE_TIMEOUT=10, one TX byte then none -> io_siwua_n low exactly one cycle, 10 cycles after it.
